debug_instr_encoder: RTL and testbench
======================================

# debug_instr_encoder

Command-to-instruction encoder for the debug/boot path. It accepts high-level register and memory access commands and emits the equivalent RV32I instruction words to the core's instruction-injection port over a valid/ready handshake. It is the inverse of the core instruction decoder: every emitted word must decode there as the intended legal instruction. A 32-bit register write expands into a LUI+ADDI pair.

## Interface
Parameters:
- CSR_SCRATCH, 12'h7B2, CSR address targeted by READ_REG (dscratch0).

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  encoder can accept a command.
- cmd_op  input  3  0 = WRITE_REG, 1 = READ_REG, 2 = LOAD, 3 = STORE, 4–7 = illegal.
- cmd_reg  input  5  rd for WRITE_REG/LOAD; source register (rs1 for READ_REG, rs2 for STORE).
- cmd_base  input  5  base register rs1 for LOAD/STORE.
- cmd_data  input  32  WRITE_REG value; LOAD/STORE offset in [11:0] ([31:12] ignored).
- instr_valid  output  1  instr holds a word to inject.
- instr_ready  input  1  core takes the word.
- instr  output  32  encoded RV32I instruction.
- instr_last  output  1  instr is the final word of the current command.
- cmd_error  output  1  one-cycle pulse: an illegal cmd_op was accepted.
- busy  output  1  state != IDLE.

## Operation
- FSM states: IDLE, EMIT1, EMIT2.
- cmd_ready = (state == IDLE).
- A command is accepted on a cycle with cmd_valid && cmd_ready. On acceptance, latch all fields and precompute both words.
- Illegal op: stay in IDLE, pulse cmd_error for one cycle, emit nothing.

WRITE_REG:
- lo = data[11:0]; hi = (data + 32'h800)[31:12], computed with 32-bit wraparound.
- If hi == 0, emit a single ADDI rd,x0,lo.
- Otherwise emit LUI rd,hi followed by ADDI rd,rd,lo.
- rd = 0 is encoded normally; no special case.

Other commands:
- READ_REG: CSRRW x0,CSR_SCRATCH,rs1. Opcode 1110011, funct3 001, rd 0.
- LOAD: LW rd,off(base). Opcode 0000011, funct3 010.
- STORE: SW rs2,off(base). Opcode 0100011, funct3 010. imm[11:5] goes to [31:25], imm[4:0] goes to [11:7].
- ADDI uses opcode 0010011, funct3 000. LUI uses opcode 0110111.

Transitions:
- IDLE → EMIT1 on a legal accept.
- EMIT1 → EMIT2 on instr_ready, if the command is a two-word WRITE_REG.
- EMIT1 → IDLE on instr_ready, otherwise.
- EMIT2 → IDLE on instr_ready.

Outputs:
- instr_valid = state ∈ {EMIT1, EMIT2}.
- instr_last is high in EMIT2, and in EMIT1 for single-word commands.
- When not valid, instr = 32'h00000013 (NOP).

## Timing
- Reset values: state IDLE, instr_valid 0, instr 32'h00000013, instr_last 0, cmd_error 0, busy 0, cmd_ready 1 (from the first cycle after rst deasserts).
- Latency: accept at cycle N gives instr_valid at N+1.
- cmd_ready is low from N+1 until the cycle after the final instr handshake.
- Throughput: at best one single-word command every 2 cycles; WRITE_REG pairs take 3 cycles.
- instr and instr_last are registered and must hold stable while instr_valid && !instr_ready, for any number of stall cycles.
- instr_valid never drops without a handshake, except on rst.
- cmd_error asserts at N+1 for an illegal accept at N.
- rst asserted in EMIT1/EMIT2 (including mid-pair): the next cycle is IDLE with instr_valid 0. The partial sequence is discarded and not resumed.
- instr_ready while instr_valid is low is ignored.

## Test plan
- WRITE_REG rd=5, data=32'h12345678 with instr_ready held high → 32'h123452B7 (last=0), then 32'h67828293 (last=1); cmd_ready high again 3 cycles after accept.
- WRITE_REG rd=1, data=32'h00000FFF (lo sign-negative, hi rounds up) → 32'h000010B7, then 32'hFFF08093.
- WRITE_REG rd=2, data=32'hFFFFF800 (hi wraps to 0) → single word 32'h80000113 with last=1; no LUI.
- READ_REG rs=10 → 32'h7B251073. LOAD rd=6, base=2, off=8 → 32'h00812303. STORE rs2=7, base=3, off=12'hFFC → 32'hFE71AE23. Each word has last=1.
- Stall: hold instr_ready=0 for 5 cycles during the WRITE_REG 32'h12345678 LUI word → instr stays 32'h123452B7, cmd_ready stays 0. Assert cmd_op=5 while cmd_ready is low → not accepted. cmd_op=5 once idle → cmd_error pulses for 1 cycle, instr_valid stays 0.
- Assert rst while in EMIT1 of a WRITE_REG pair → next cycle instr_valid=0, busy=0, cmd_ready=1, instr=32'h00000013; the ADDI word is never emitted.

Source files
------------

// File: rtl/debug_instr_encoder.sv
// Debug/boot-path command encoder: turns register and memory access commands
// into RV32I instruction words for the core's instruction-injection port.
module debug_instr_encoder #(
    parameter logic [11:0] CSR_SCRATCH = 12'h7B2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [4:0]  cmd_reg,
    input  logic [4:0]  cmd_base,
    input  logic [31:0] cmd_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic        instr_last,
    output logic        cmd_error,
    output logic        busy
);

    localparam logic [31:0] NOP       = 32'h00000013;
    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_SYSTEM = 7'b1110011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;

    typedef enum logic [1:0] {
        IDLE,
        EMIT1,
        EMIT2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] word1_d;
    logic [31:0] word2_d;
    logic        two_word_d;
    logic [31:0] word2_q;
    logic        two_word_q;
    logic [31:0] instr_q;
    logic        last_q;
    logic        err_q;

    logic        accept;
    logic        legal;
    logic [11:0] lo;
    logic [19:0] hi;

    assign accept = cmd_valid && (state == IDLE);
    assign legal  = !cmd_op[2];
    assign lo     = cmd_data[11:0];
    // ADDI sign-extends lo, so the upper part is rounded up whenever lo[11] is set.
    assign hi     = cmd_data[31:12] + {19'd0, cmd_data[11]};

    always_comb begin
        word1_d    = NOP;
        word2_d    = NOP;
        two_word_d = 1'b0;
        case (cmd_op)
            3'd0: begin
                if (hi == 20'd0) begin
                    word1_d = {lo, 5'd0, 3'b000, cmd_reg, OP_IMM};
                end else begin
                    word1_d    = {hi, cmd_reg, OP_LUI};
                    word2_d    = {lo, cmd_reg, 3'b000, cmd_reg, OP_IMM};
                    two_word_d = 1'b1;
                end
            end
            3'd1:    word1_d = {CSR_SCRATCH, cmd_reg, 3'b001, 5'd0, OP_SYSTEM};
            3'd2:    word1_d = {lo, cmd_base, 3'b010, cmd_reg, OP_LOAD};
            3'd3:    word1_d = {lo[11:5], cmd_reg, cmd_base, 3'b010, lo[4:0], OP_STORE};
            default: word1_d = NOP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && legal) begin
                    state_next = EMIT1;
                end
            end
            EMIT1: begin
                if (instr_ready) begin
                    state_next = two_word_q ? EMIT2 : IDLE;
                end
            end
            EMIT2: begin
                if (instr_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output words are registered and only change on accept or handshake, so they hold through stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q    <= NOP;
            last_q     <= 1'b0;
            err_q      <= 1'b0;
            word2_q    <= NOP;
            two_word_q <= 1'b0;
        end else begin
            err_q <= accept && !legal;
            case (state)
                IDLE: begin
                    if (accept && legal) begin
                        instr_q    <= word1_d;
                        last_q     <= !two_word_d;
                        word2_q    <= word2_d;
                        two_word_q <= two_word_d;
                    end
                end
                EMIT1: begin
                    if (instr_ready) begin
                        if (two_word_q) begin
                            instr_q <= word2_q;
                            last_q  <= 1'b1;
                        end else begin
                            instr_q <= NOP;
                            last_q  <= 1'b0;
                        end
                    end
                end
                EMIT2: begin
                    if (instr_ready) begin
                        instr_q <= NOP;
                        last_q  <= 1'b0;
                    end
                end
                default: begin
                    instr_q <= NOP;
                    last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign instr_valid = (state != IDLE);
    assign busy        = (state != IDLE);
    assign cmd_ready   = (state == IDLE);
    assign instr       = instr_q;
    assign instr_last  = last_q;
    assign cmd_error   = err_q;

endmodule

// File: tb/tb_debug_instr_encoder.sv
// Bench for debug_instr_encoder: directed literal cases plus randomized traffic
// checked every cycle against a queue-based model of the expected instruction stream.
module tb_debug_instr_encoder;

    localparam logic [11:0] CSR = 12'h7B2;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [4:0]  cmd_reg;
    logic [4:0]  cmd_base;
    logic [31:0] cmd_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        instr_last;
    logic        cmd_error;
    logic        busy;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct packed {
        logic [31:0] word;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    logic exp_err = 1'b0;
    logic model_idle;

    debug_instr_encoder #(.CSR_SCRATCH(CSR)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_reg    (cmd_reg),
        .cmd_base   (cmd_base),
        .cmd_data   (cmd_data),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .instr_last (instr_last),
        .cmd_error  (cmd_error),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] f_addi(logic [11:0] imm, logic [4:0] rs1, logic [4:0] rd);
        return (32'(imm) << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | 32'h13;
    endfunction

    function automatic logic [31:0] f_lui(logic [19:0] upper, logic [4:0] rd);
        return (32'(upper) << 12) | (32'(rd) << 7) | 32'h37;
    endfunction

    function automatic logic [31:0] f_csrrw(logic [4:0] rs1);
        return (32'(CSR) << 20) | (32'(rs1) << 15) | (32'd1 << 12) | 32'h73;
    endfunction

    function automatic logic [31:0] f_lw(logic [11:0] off, logic [4:0] base, logic [4:0] rd);
        return (32'(off) << 20) | (32'(base) << 15) | (32'd2 << 12) | (32'(rd) << 7) | 32'h03;
    endfunction

    function automatic logic [31:0] f_sw(logic [11:0] off, logic [4:0] base, logic [4:0] rs2);
        return (32'(off / 32) << 25) | (32'(rs2) << 20) | (32'(base) << 15)
             | (32'd2 << 12) | (32'(off % 32) << 7) | 32'h23;
    endfunction

    task automatic modelAccept(logic [2:0] op, logic [4:0] rg, logic [4:0] base, logic [31:0] data);
        logic [31:0] rounded;
        logic [19:0] upper;
        logic [11:0] low;
        low     = data[11:0];
        rounded = data + 32'h800;
        upper   = rounded[31:12];
        case (op)
            3'd0: begin
                if (upper == 20'd0) begin
                    exp_q.push_back('{word: f_addi(low, 5'd0, rg), last: 1'b1});
                end else begin
                    exp_q.push_back('{word: f_lui(upper, rg), last: 1'b0});
                    exp_q.push_back('{word: f_addi(low, rg, rg), last: 1'b1});
                end
            end
            3'd1:    exp_q.push_back('{word: f_csrrw(rg), last: 1'b1});
            3'd2:    exp_q.push_back('{word: f_lw(low, base, rg), last: 1'b1});
            default: exp_q.push_back('{word: f_sw(low, base, rg), last: 1'b1});
        endcase
    endtask

    // Model advances on each rising edge using the inputs the DUT sees at that edge.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_err = 1'b0;
        end else begin
            model_idle = (exp_q.size() == 0);
            exp_err    = 1'b0;
            if (!model_idle && instr_ready) begin
                void'(exp_q.pop_front());
            end
            if (model_idle && cmd_valid) begin
                if (cmd_op > 3'd3) begin
                    exp_err = 1'b1;
                end else begin
                    modelAccept(cmd_op, cmd_reg, cmd_base, cmd_data);
                end
            end
        end
    end

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t front;
        logic ev;
        ev    = (exp_q.size() != 0);
        front = ev ? exp_q[0] : '{word: NOP, last: 1'b0};
        checkOutput("model.instr_valid", 32'(instr_valid), 32'(ev));
        checkOutput("model.instr", instr, front.word);
        checkOutput("model.instr_last", 32'(instr_last), 32'(front.last));
        checkOutput("model.cmd_ready", 32'(cmd_ready), 32'(!ev));
        checkOutput("model.busy", 32'(busy), 32'(ev));
        checkOutput("model.cmd_error", 32'(cmd_error), 32'(exp_err));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds a command for exactly one rising edge; caller sits just after a rising edge.
    task automatic applyStimulus(logic [2:0] op, logic [4:0] rg, logic [4:0] base, logic [31:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_reg   = rg;
        cmd_base  = base;
        cmd_data  = data;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic expectWord(string name, logic [31:0] word, logic last);
        @(negedge clk);
        checkOutput({name, ".instr"}, instr, word);
        checkOutput({name, ".last"}, 32'(instr_last), 32'(last));
        checkOutput({name, ".valid"}, 32'(instr_valid), 32'd1);
    endtask

    initial begin
        #200000;
        n_fails++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_op      = 3'd0;
        cmd_reg     = 5'd0;
        cmd_base    = 5'd0;
        cmd_data    = 32'd0;
        instr_ready = 1'b1;
        repeat (2) tick();
        rst = 1'b0;

        @(negedge clk);
        checkOutput("reset.instr", instr, NOP);
        checkOutput("reset.valid", 32'(instr_valid), 32'd0);
        checkOutput("reset.cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("reset.busy", 32'(busy), 32'd0);
        checkOutput("reset.last", 32'(instr_last), 32'd0);
        checkOutput("reset.cmd_error", 32'(cmd_error), 32'd0);
        tick();

        applyStimulus(3'd0, 5'd5, 5'd0, 32'h12345678);
        expectWord("wr5.lui", 32'h123452B7, 1'b0);
        expectWord("wr5.addi", 32'h67828293, 1'b1);
        @(negedge clk);
        checkOutput("wr5.ready_after", 32'(cmd_ready), 32'd1);
        tick();

        applyStimulus(3'd0, 5'd1, 5'd0, 32'h00000FFF);
        expectWord("wr1.lui", 32'h000010B7, 1'b0);
        expectWord("wr1.addi", 32'hFFF08093, 1'b1);
        tick();

        applyStimulus(3'd0, 5'd2, 5'd0, 32'hFFFFF800);
        expectWord("wr2.single", 32'h80000113, 1'b1);
        tick();

        applyStimulus(3'd1, 5'd10, 5'd0, 32'd0);
        expectWord("read_reg", 32'h7B251073, 1'b1);
        tick();
        applyStimulus(3'd2, 5'd6, 5'd2, 32'h00000008);
        expectWord("load", 32'h00812303, 1'b1);
        tick();
        applyStimulus(3'd3, 5'd7, 5'd3, 32'h00000FFC);
        expectWord("store", 32'hFE71AE23, 1'b1);
        tick();

        instr_ready = 1'b0;
        applyStimulus(3'd0, 5'd5, 5'd0, 32'h12345678);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stall.instr", instr, 32'h123452B7);
            checkOutput("stall.cmd_ready", 32'(cmd_ready), 32'd0);
        end
        tick();
        applyStimulus(3'd5, 5'd0, 5'd0, 32'd0);
        @(negedge clk);
        checkOutput("busy_illegal.cmd_error", 32'(cmd_error), 32'd0);
        checkOutput("busy_illegal.instr", instr, 32'h123452B7);
        tick();
        instr_ready = 1'b1;
        expectWord("stall.lui_release", 32'h123452B7, 1'b0);
        expectWord("stall.addi", 32'h67828293, 1'b1);
        tick();

        applyStimulus(3'd5, 5'd0, 5'd0, 32'd0);
        @(negedge clk);
        checkOutput("illegal.cmd_error", 32'(cmd_error), 32'd1);
        checkOutput("illegal.valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        checkOutput("illegal.pulse_end", 32'(cmd_error), 32'd0);
        tick();

        instr_ready = 1'b0;
        applyStimulus(3'd0, 5'd5, 5'd0, 32'h12345678);
        expectWord("rst_mid.lui", 32'h123452B7, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst         = 1'b0;
        instr_ready = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid.valid", 32'(instr_valid), 32'd0);
        checkOutput("rst_mid.busy", 32'(busy), 32'd0);
        checkOutput("rst_mid.cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("rst_mid.instr", instr, NOP);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rst_mid.no_resume", 32'(instr_valid), 32'd0);
        end
        tick();

        for (int i = 0; i < 600; i++) begin
            logic [3:0] pick;
            rst         = ($urandom_range(0, 99) == 0);
            cmd_valid   = $urandom_range(0, 1) == 1;
            cmd_op      = 3'($urandom_range(0, 7));
            cmd_reg     = 5'($urandom);
            cmd_base    = 5'($urandom);
            pick        = 4'($urandom_range(0, 11));
            case (pick)
                4'd0:    cmd_data = 32'h00000000;
                4'd1:    cmd_data = 32'hFFFFF800;
                4'd2:    cmd_data = 32'h000007FF;
                4'd3:    cmd_data = 32'h00000800;
                4'd4:    cmd_data = 32'hFFFFFFFF;
                4'd5:    cmd_data = 32'h7FFFF800;
                default: cmd_data = $urandom;
            endcase
            instr_ready = $urandom_range(0, 3) != 0;
            tick();
        end

        rst         = 1'b0;
        cmd_valid   = 1'b0;
        instr_ready = 1'b1;
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
